mc_control_unit: RTL
====================

Name: mc_control_unit

Overview:
- Multi-cycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction through IF/ID/EX/MEM/WB states and drives per-state datapath enables for a shared-memory, single-ALU datapath.
- Adds memory wait-state handshake, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register opcode field and the multi-cycle datapath; ALU function decode (funct) stays in the existing ALU control block.

Parameters:
- OP_W, 6, opcode field width.
- ALUOP_W, 3, ALUop width to ALU control block (bit0 R_type, bit1 OR, bit2 SUB; 0 = ADD).
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  OP_W  opcode from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- pc_wr  out  1  PC write enable (unconditional or taken branch).
- ir_wr  out  1  instruction register write.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- reg_wr  out  1  register file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ext_op  out  1  1 = sign-extend, 0 = zero-extend.
- alu_op  out  ALUOP_W  ALU operation class.
- illegal  out  1  one-cycle pulse on unknown opcode.
- instr_cnt  out  CNT_W  retired instructions.
- state  out  4  current state (debug).

Behaviour:
- States: S_IF, S_ID, S_EX_R, S_EX_I, S_EX_MA (address calc), S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP.
- Reset: state = S_IF. instr_cnt = 0. All enables (pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, illegal) = 0. All selects = 0.
- Outputs are Moore, decoded from state and the registered op. Exception: pc_wr in S_BR = zero, and pc_wr/ir_wr in S_IF are gated by mem_ready.
- S_IF: mem_rd = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 0, pc_src = 00.
  - mem_ready = 0: hold S_IF with no writes.
  - mem_ready = 1: ir_wr = 1, pc_wr = 1, go to S_ID.
- S_ID: alu_src_a = 0, alu_src_b = 11, ext_op = 1, alu_op = 0 (branch target into ALUOut). Dispatch on op:
  - 000000 → S_EX_R
  - 001101 ori, 001001 addiu → S_EX_I
  - 100011 lw, 101011 sw → S_EX_MA
  - 000100 beq → S_BR
  - 000010 j → S_JMP
  - any other opcode: illegal = 1 for this cycle, next state S_IF, no architectural writes.
- S_EX_R: alu_src_a = 1, alu_src_b = 00, alu_op = 001 → S_WB_R.
- S_EX_I: alu_src_a = 1, alu_src_b = 10. ori: ext_op = 0, alu_op = 010. addiu: ext_op = 1, alu_op = 000. Next S_WB_I.
- S_EX_MA: alu_src_a = 1, alu_src_b = 10, ext_op = 1, alu_op = 0. lw → S_MEM_RD, sw → S_MEM_WR.
- S_MEM_RD: mem_rd = 1, i_or_d = 1. Hold until mem_ready, then → S_WB_MEM.
- S_MEM_WR: mem_wr = 1, i_or_d = 1. Hold until mem_ready, then → S_IF (retire).
- S_WB_R: reg_wr = 1, reg_dst = 1, mem_to_reg = 0.
- S_WB_I: reg_wr = 1, reg_dst = 0, mem_to_reg = 0.
- S_WB_MEM: reg_wr = 1, reg_dst = 0, mem_to_reg = 1.
- All WB states → S_IF (retire).
- S_BR: alu_src_a = 1, alu_src_b = 00, alu_op = 100, pc_src = 01, pc_wr = zero → S_IF (retire).
- S_JMP: pc_src = 10, pc_wr = 1 → S_IF (retire).
- Latency with zero wait states: beq/j 3 cycles, R/ori/addiu/sw 4, lw 5. Each wait cycle adds one.
- Retire: instr_cnt increments by 1 on the transition into S_IF from a retiring state. It wraps modulo 2^CNT_W. Illegal opcodes do not retire.
- mem_rd/mem_wr stay asserted and stable throughout a wait. A mem_ready seen outside IF/MEM states is ignored.
- Reset asserted mid-instruction: state and counter clear immediately and all enables drop combinationally with state.
- An unreachable state encoding recovers to S_IF on the next clock.

Optional Feature:
- MC_JAL_EN defined:
  - Opcode 000011 (jal) dispatches from S_ID to S_JAL.
  - S_JAL: pc_wr = 1, pc_src = 10, reg_wr = 1. Adds output link_sel (1 bit, asserted only in S_JAL) telling the datapath to write PC into $31. Next S_IF, retires, 3 cycles.
- Undefined: 000011 is illegal and the link_sel port does not exist.

Decomposition:
- Shared package mc_pkg: state encodings, opcode constants (OP_RTYPE, OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL), alu_src_b and pc_src select constants, ALUop class constants.
- One sub-module, mc_ctrl_decode: purely combinational state+op → control-word decode, instantiated by the FSM top. The top holds only the state register, next-state logic and counter.

Test Plan:
- Reset release, mem_ready = 1, op = 000000 → states IF, ID, EX_R, WB_R; reg_wr = 1 and reg_dst = 1 only in cycle 4; instr_cnt = 1 after cycle 4.
- lw (100011) with mem_ready low 2 cycles in MEM_RD → 7 cycles total; mem_rd and i_or_d = 1 held for 3 cycles; reg_wr and mem_to_reg = 1 in WB_MEM.
- beq with zero = 1 then zero = 0 → pc_wr = 1 with pc_src = 01 in cycle 3 of the first; pc_wr = 0 in the second; instr_cnt increments by 2.
- ori (001101) → ext_op = 0, alu_op = 010 in EX_I. addiu (001001) → ext_op = 1, alu_op = 000.
- op = 111111 → illegal pulses 1 cycle in ID, returns to IF, no reg_wr/mem_wr, instr_cnt unchanged. With MC_JAL_EN, op = 000011 → S_JAL, link_sel = 1, reg_wr = 1, pc_src = 10.
- rst_n low during S_MEM_WR asynchronously → mem_wr = 0 and state = S_IF before the next clock edge; instr_cnt = 0.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS control unit (MC_JAL_EN adds jal).
package mc_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_R   = 4'd2,
    S_EX_I   = 4'd3,
    S_EX_MA  = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_I   = 4'd8,
    S_WB_MEM = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11
`ifdef MC_JAL_EN
    , S_JAL  = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_R   = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       ext_op;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] o);
    case (o)
      OP_RTYPE, OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
`ifdef MC_JAL_EN
      OP_JAL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_if.sv
// rtl/mc_if.sv - controller <-> multi-cycle datapath signal bundle (link_sel only with MC_JAL_EN).
interface mc_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
);
  logic [OP_W-1:0]    op;
  logic               zero;
  logic               mem_ready;
  logic               pc_wr;
  logic               ir_wr;
  logic               i_or_d;
  logic               mem_rd;
  logic               mem_wr;
  logic               reg_wr;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_src;
  logic               ext_op;
  logic [ALUOP_W-1:0] alu_op;
`ifdef MC_JAL_EN
  logic               link_sel;
`endif

  modport master (
    input  op, zero, mem_ready,
    output pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, ext_op, alu_op
`ifdef MC_JAL_EN
           , link_sel
`endif
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, ext_op, alu_op
`ifdef MC_JAL_EN
           , link_sel
`endif
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state+opcode to control-word decode (MC_JAL_EN adds S_JAL).
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] op_q,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl,
`ifdef MC_JAL_EN
  output logic       link_sel,
`endif
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
`ifdef MC_JAL_EN
    link_sel = 1'b0;
`endif
    case (state)
      S_IF: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_wr     = mem_ready;
        ctrl.pc_wr     = mem_ready;
      end
      S_ID: begin
        // Branch target is computed speculatively into ALUOut here.
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.ext_op    = 1'b1;
        illegal        = !op_legal(op);
      end
      S_EX_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_R;
      end
      S_EX_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (op_q == OP_ORI) begin
          ctrl.ext_op = 1'b0;
          ctrl.alu_op = ALU_OR;
        end else begin
          ctrl.ext_op = 1'b1;
          ctrl.alu_op = ALU_ADD;
        end
      end
      S_EX_MA: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = 1'b1;
      end
      S_MEM_RD: begin
        ctrl.mem_rd = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_wr = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_WB_R: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      S_WB_I:   ctrl.reg_wr = 1'b1;
      S_WB_MEM: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_BR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_wr     = zero;
      end
      S_JMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_wr  = 1'b1;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_wr  = 1'b1;
        ctrl.reg_wr = 1'b1;
        link_sel    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS control FSM with wait states and retire counter.
// Define MC_JAL_EN to add the jal instruction and the link_sel output.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_if.master             dp,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  state_t     state_q, state_d;
  logic [5:0] op_live, op_q;
  logic       retire;
  ctrl_t      dec, ctrl;
  logic       dec_illegal;
`ifdef MC_JAL_EN
  logic       dec_link;
`endif

  assign op_live = 6'(dp.op);

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .op        (op_live),
    .op_q      (op_q),
    .zero      (dp.zero),
    .mem_ready (dp.mem_ready),
    .ctrl      (dec),
`ifdef MC_JAL_EN
    .link_sel  (dec_link),
`endif
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      op_q      <= '0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= op_live;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = S_IF;
    retire  = 1'b0;
    case (state_q)
      S_IF: state_d = dp.mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (op_live)
          OP_RTYPE:         state_d = S_EX_R;
          OP_ORI, OP_ADDIU: state_d = S_EX_I;
          OP_LW, OP_SW:     state_d = S_EX_MA;
          OP_BEQ:           state_d = S_BR;
          OP_J:             state_d = S_JMP;
`ifdef MC_JAL_EN
          OP_JAL:           state_d = S_JAL;
`endif
          default:          state_d = S_IF;
        endcase
      end
      S_EX_R:   state_d = S_WB_R;
      S_EX_I:   state_d = S_WB_I;
      S_EX_MA:  state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_d = dp.mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: begin
        state_d = dp.mem_ready ? S_IF : S_MEM_WR;
        retire  = dp.mem_ready;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
`endif
      default: state_d = S_IF;
    endcase
  end

  // While reset is held every enable and select is forced low, not just the IF decode.
  assign ctrl    = rst_n ? dec : '0;
  assign illegal = rst_n & dec_illegal;
  assign state   = state_q;

  assign dp.pc_wr      = ctrl.pc_wr;
  assign dp.ir_wr      = ctrl.ir_wr;
  assign dp.i_or_d     = ctrl.i_or_d;
  assign dp.mem_rd     = ctrl.mem_rd;
  assign dp.mem_wr     = ctrl.mem_wr;
  assign dp.reg_wr     = ctrl.reg_wr;
  assign dp.reg_dst    = ctrl.reg_dst;
  assign dp.mem_to_reg = ctrl.mem_to_reg;
  assign dp.alu_src_a  = ctrl.alu_src_a;
  assign dp.alu_src_b  = ctrl.alu_src_b;
  assign dp.pc_src     = ctrl.pc_src;
  assign dp.ext_op     = ctrl.ext_op;
  assign dp.alu_op     = ALUOP_W'(ctrl.alu_op);
`ifdef MC_JAL_EN
  assign dp.link_sel   = rst_n & dec_link;
`endif

endmodule
